udp_tx_sched: RTL and testbench

//  Round-robin scheduler that shares one udp_tx frame engine among NUM_REQ

---
 rtl/udp_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_udp_tx_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one udp_tx frame engine among NUM_REQ sources.
// Each frame: arbitrate, start, wait for done or watchdog, acknowledge, inter-frame gap.
module udp_tx_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned IFG     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_err,
    output logic                     tx_start,
    output logic [LEN_W-1:0]         tx_len,
    output logic [IDX_W-1:0]         tx_sel,
    input  logic                     tx_done,
    output logic                     busy
);

    localparam int unsigned GAP_W    = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_DONE,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               abort_q, abort_d;
    logic [15:0]        tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               found_c;
    logic [IDX_W-1:0]   win_c;
    logic [LEN_W-1:0]   win_len_c;
    logic [LEN_W-1:0]   len_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
    end

    // First pending source after the last one served, wrapping modulo NUM_REQ.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!found_c && req[IDX_W'((32'(last_ptr_q) + i) % NUM_REQ)]) begin
                found_c = 1'b1;
                win_c   = IDX_W'((32'(last_ptr_q) + i) % NUM_REQ);
            end
        end
        win_len_c = len_arr[win_c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_ptr_q <= IDX_W'(NUM_REQ - 1);
            sel_q      <= '0;
            len_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            tmo_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
        end
    end

    // Pulse outputs are registered from the state they belong to, so they lag it by one cycle.
    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        sel_d      = sel_q;
        len_d      = len_q;
        grant_d    = grant_q;
        done_d     = '0;
        err_d      = '0;
        start_d    = 1'b0;
        abort_d    = abort_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;

        case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end
            S_ARB: begin
                if (!found_c) begin
                    state_d = S_IDLE;
                end else begin
                    sel_d   = win_c;
                    len_d   = win_len_c;
                    grant_d = NUM_REQ'(1) << win_c;
                    abort_d = 1'b0;
                    tmo_d   = '0;
                    state_d = (win_len_c == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                // tx_done takes priority over a watchdog expiring in the same cycle
                if (tx_done) begin
                    state_d = S_DONE;
                end else if (tmo_d == TMO_LAST) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (abort_q) err_d  = grant_q;
                else         done_d = grant_q;
                grant_d    = '0;
                last_ptr_d = sel_q;
                gap_d      = '0;
                state_d    = (IFG > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(IFG - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign grant    = grant_q;
    assign req_done = done_q;
    assign req_err  = err_q;
    assign tx_start = start_q;
    assign tx_len   = len_q;
    assign tx_sel   = sel_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed self-checking bench for udp_tx_sched (TIMEOUT=100, IFG=12).
module tb_udp_tx_sched;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned LEN_W   = 11;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned IFG     = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       req_done;
    logic [NUM_REQ-1:0]       req_err;
    logic                     tx_start;
    logic [LEN_W-1:0]         tx_len;
    logic [IDX_W-1:0]         tx_sel;
    logic                     tx_done;
    logic                     busy;

    int n_tests = 0;
    int n_fail  = 0;

    udp_tx_sched #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT),
        .IFG     (IFG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_len  (req_len),
        .grant    (grant),
        .req_done (req_done),
        .req_err  (req_err),
        .tx_start (tx_start),
        .tx_len   (tx_len),
        .tx_sel   (tx_sel),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int idx, input int len);
        req_len[idx*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("tx_start_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        while (!(|req_done) && !(|req_err) && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // One complete frame for source idx; req is left untouched.
    task automatic serve(input int idx, input int len);
        wait_start(40);
        check("serve_sel",   32'(tx_sel), 32'(idx));
        check("serve_len",   32'(tx_len), 32'(len));
        check("serve_grant", 32'(grant),  32'(1) << idx);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_ack(8);
        check("serve_done", 32'(req_done), 32'(1) << idx);
        check("serve_err",  32'(req_err),  32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_len = '0;
        tx_done = 1'b0;

        // Reset with every source requesting
        req = 4'b1111;
        set_len(0, 100);
        set_len(1, 200);
        set_len(2, 300);
        set_len(3, 400);
        repeat (3) tick();
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_done",     32'(req_done), 32'd0);
        check("rst_err",      32'(req_err),  32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_len",   32'(tx_len),   32'd0);
        check("rst_tx_sel",   32'(tx_sel),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("first_grant", 32'(grant), 32'b0001);
        tick();

        // Fairness with all four held: 0,1,2,3,0
        for (int n = 0; n < 5; n++) serve(n % 4, 100 * (n % 4 + 1));
        req = '0;
        wait_idle(30);

        // Single source, tx_done 10 clocks after tx_start
        set_len(2, 64);
        req = 4'b0100;
        repeat (3) tick();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_sel",   32'(tx_sel),   32'd2);
        check("single_len",   32'(tx_len),   32'd64);
        check("single_grant", 32'(grant),    32'b0100);
        tick();
        check("start_pulse_width", 32'(tx_start), 32'd0);
        repeat (8) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("single_done_early", 32'(req_done), 32'd0);
        tick();
        check("single_done",     32'(req_done), 32'b0100);
        check("single_busy_gap", 32'(busy),     32'd1);
        req = '0;
        repeat (11) tick();
        check("gap_last_busy", 32'(busy), 32'd1);
        tick();
        check("gap_end_busy", 32'(busy),   32'd0);
        check("hold_sel",     32'(tx_sel), 32'd2);
        check("hold_len",     32'(tx_len), 32'd64);

        // Watchdog: no tx_done
        set_len(0, 10);
        req = 4'b0001;
        repeat (3) tick();
        check("tmo_start", 32'(tx_start), 32'd1);
        repeat (99) tick();
        check("tmo_err_early", 32'(req_err), 32'd0);
        tick();
        check("tmo_err",  32'(req_err),  32'b0001);
        check("tmo_done", 32'(req_done), 32'd0);
        req = '0;
        tick();
        check("tmo_err_width", 32'(req_err), 32'd0);
        wait_idle(20);

        // Zero-length frame: acknowledged without tx_start
        set_len(1, 0);
        req = 4'b0010;
        tick();
        check("zl_start_1", 32'(tx_start), 32'd0);
        tick();
        check("zl_start_2", 32'(tx_start), 32'd0);
        check("zl_done_early", 32'(req_done), 32'd0);
        tick();
        check("zl_done",    32'(req_done), 32'b0010);
        check("zl_start_3", 32'(tx_start), 32'd0);
        check("zl_len",     32'(tx_len),   32'd0);
        check("zl_sel",     32'(tx_sel),   32'd1);
        req = '0;
        tick();
        check("zl_start_4", 32'(tx_start), 32'd0);
        wait_idle(20);

        // Request withdrawn before arbitration resolves
        req = 4'b0100;
        tick();
        check("drop_busy_arb", 32'(busy), 32'd1);
        req = '0;
        tick();
        check("drop_busy", 32'(busy),  32'd0);
        check("drop_grant", 32'(grant), 32'd0);

        // tx_done on the watchdog's terminal cycle
        set_len(3, 5);
        req = 4'b1000;
        repeat (3) tick();
        check("term_start", 32'(tx_start), 32'd1);
        repeat (98) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check("term_done", 32'(req_done), 32'b1000);
        check("term_err",  32'(req_err),  32'd0);
        req = '0;
        wait_idle(20);

        // Reset in WAIT aborts silently
        set_len(0, 7);
        req = 4'b0001;
        repeat (3) tick();
        check("rw_start", 32'(tx_start), 32'd1);
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        check("rw_busy",  32'(busy),   32'd0);
        check("rw_grant", 32'(grant),  32'd0);
        check("rw_len",   32'(tx_len), 32'd0);
        rst     = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rw_no_done", 32'(req_done), 32'd0);
            check("rw_no_err",  32'(req_err),  32'd0);
            tick();
        end
        set_len(1, 9);
        req = 4'b0011;
        tick();
        tick();
        check("rw_rr_restart", 32'(grant), 32'b0001);
        serve(0, 7);
        req = '0;
        wait_idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
